// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one signed add/subtract unit between two
// requesters. Each result and its flags go into a single-entry output buffer
// with a valid/ready handshake.
// Optional feature macro: ALU_ARB_SAT_EN. When defined, the result saturates
// to the signed range. When undefined (the default), the result wraps modulo
// 2^WIDTH.

module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_vld,
    output logic             req0_rdy,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_vld,
    output logic             req1_rdy,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_ovfl,
    output logic             rsp_zero,
    output logic             rsp_sign
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bufState_e;

    bufState_e        state_q, state_d;
    logic             last_q, last_d;
    logic             rspId_q, rspId_d;
    logic [WIDTH-1:0] rspResult_q, rspResult_d;
    logic             rspOvfl_q, rspOvfl_d;
    logic             rspZero_q, rspZero_d;
    logic             rspSign_q, rspSign_d;

    logic             canTake;
    logic             grantId;
    logic             accept;
    logic [WIDTH-1:0] selA;
    logic [WIDTH-1:0] selB;
    logic             selOp;
    logic [WIDTH:0]   exactVal;
    logic             outOfRange;
    logic [WIDTH-1:0] aluResult;

    // Round-robin grant: a lone requester always wins. On contention the
    // requester not served last wins. Ready never feeds back into any valid.
    always_comb begin
        canTake = (state_q == EMPTY) || rsp_rdy;
        grantId = 1'b0;
        if (req0_vld && req1_vld) begin
            grantId = ~last_q;
        end else if (req1_vld) begin
            grantId = 1'b1;
        end
        req0_rdy = canTake && req0_vld && (grantId == 1'b0);
        req1_rdy = canTake && req1_vld && (grantId == 1'b1);
        accept   = req0_rdy || req1_rdy;
    end

    // Operand mux and exact WIDTH+1 add/sub, then clamp or wrap into WIDTH bits
    always_comb begin
        selA       = grantId ? req1_a  : req0_a;
        selB       = grantId ? req1_b  : req0_b;
        selOp      = grantId ? req1_op : req0_op;
        exactVal   = selOp ? ({selA[WIDTH-1], selA} - {selB[WIDTH-1], selB})
                           : ({selA[WIDTH-1], selA} + {selB[WIDTH-1], selB});
        outOfRange = exactVal[WIDTH] ^ exactVal[WIDTH-1];
`ifdef ALU_ARB_SAT_EN
        if (outOfRange) begin
            aluResult = exactVal[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            aluResult = exactVal[WIDTH-1:0];
        end
`else
        aluResult = exactVal[WIDTH-1:0];
`endif
    end

    // Buffer FSM next state and buffer load. Contents hold unless a request is accepted.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        rspId_d     = rspId_q;
        rspResult_d = rspResult_q;
        rspOvfl_d   = rspOvfl_q;
        rspZero_d   = rspZero_q;
        rspSign_d   = rspSign_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (rsp_rdy && !accept) begin
                    state_d = EMPTY;
                end
            end
        endcase
        if (accept) begin
            last_d      = req1_rdy;
            rspId_d     = req1_rdy;
            rspResult_d = aluResult;
            rspOvfl_d   = outOfRange;
            rspZero_d   = (aluResult == '0);
            rspSign_d   = aluResult[WIDTH-1];
        end
    end

    // State registers. Reset empties the buffer at once, and last=1 lets req0 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            last_q      <= 1'b1;
            rspId_q     <= 1'b0;
            rspResult_q <= '0;
            rspOvfl_q   <= 1'b0;
            rspZero_q   <= 1'b0;
            rspSign_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            rspId_q     <= rspId_d;
            rspResult_q <= rspResult_d;
            rspOvfl_q   <= rspOvfl_d;
            rspZero_q   <= rspZero_d;
            rspSign_q   <= rspSign_d;
        end
    end

    assign rsp_vld    = (state_q == FULL);
    assign rsp_id     = rspId_q;
    assign rsp_result = rspResult_q;
    assign rsp_ovfl   = rspOvfl_q;
    assign rsp_zero   = rspZero_q;
    assign rsp_sign   = rspSign_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic for alu_arbiter.
// Results are compared against a behavioural model that uses integer arithmetic.
// The model honours ALU_ARB_SAT_EN in the same way as the design.

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_vld, req0_rdy, req0_op;
    logic [15:0] req0_a, req0_b;
    logic        req1_vld, req1_rdy, req1_op;
    logic [15:0] req1_a, req1_b;
    logic        rsp_vld, rsp_rdy, rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_ovfl, rsp_zero, rsp_sign;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          mVld;
    bit          mLast;
    bit          mId;
    logic [15:0] mRes;
    bit          mOv, mZ, mS;
    int          wait0, wait1;
    int          nAccepted, nConsumed;

    alu_arbiter #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_vld   (req0_vld),
        .req0_rdy   (req0_rdy),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_vld   (req1_vld),
        .req1_rdy   (req1_rdy),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_vld    (rsp_vld),
        .rsp_rdy    (rsp_rdy),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ovfl   (rsp_ovfl),
        .rsp_zero   (rsp_zero),
        .rsp_sign   (rsp_sign)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Integer reference for the add/sub with range handling
    function automatic void refAlu(input logic [15:0] a, input logic [15:0] b, input logic op,
                                   output logic [15:0] res, output bit ov, output bit z, output bit s);
        int ea;
        int eb;
        int ex;
        ea = $signed(a);
        eb = $signed(b);
        ex = op ? (ea - eb) : (ea + eb);
        ov = (ex > 32767) || (ex < -32768);
`ifdef ALU_ARB_SAT_EN
        if (ex > 32767)       res = 16'h7FFF;
        else if (ex < -32768) res = 16'h8000;
        else                  res = ex[15:0];
`else
        res = ex[15:0];
`endif
        z = (res == 16'h0000);
        s = res[15];
    endfunction

    function automatic logic [15:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            4:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock cycle: check DUT against the model at negedge, then advance the model
    task automatic tick(input bit autoDrop);
        bit          canTake, g0, g1, a0, a1;
        logic [15:0] r;
        bit          ov, z, s;
        @(negedge clk);
        canTake = !mVld || rsp_rdy;
        g0 = req0_vld && (!req1_vld || mLast);
        g1 = req1_vld && (!req0_vld || !mLast);
        a0 = canTake && g0;
        a1 = canTake && g1;
        checkOutput("accept0", req0_vld && req0_rdy, a0);
        checkOutput("accept1", req1_vld && req1_rdy, a1);
        if (!canTake) begin
            checkOutput("bp_rdy0", req0_rdy, 0);
            checkOutput("bp_rdy1", req1_rdy, 0);
        end
        checkOutput("rsp_vld", rsp_vld, mVld);
        if (mVld) begin
            checkOutput("rsp_id", rsp_id, mId);
            checkOutput("rsp_result", rsp_result, mRes);
            checkOutput("rsp_ovfl", rsp_ovfl, mOv);
            checkOutput("rsp_zero", rsp_zero, mZ);
            checkOutput("rsp_sign", rsp_sign, mS);
        end
        if (!req0_vld || req0_rdy) wait0 = 0; else if (canTake) wait0++;
        if (!req1_vld || req1_rdy) wait1 = 0; else if (canTake) wait1++;
        checkOutput("starve0", wait0 > 2, 0);
        checkOutput("starve1", wait1 > 2, 0);
        if (req0_vld && req0_rdy) nAccepted++;
        if (req1_vld && req1_rdy) nAccepted++;
        if (rsp_vld && rsp_rdy)   nConsumed++;
        if (a0 || a1) begin
            if (a1) refAlu(req1_a, req1_b, req1_op, r, ov, z, s);
            else    refAlu(req0_a, req0_b, req0_op, r, ov, z, s);
            mVld = 1; mId = a1; mLast = a1;
            mRes = r; mOv = ov; mZ = z; mS = s;
        end else if (rsp_rdy) begin
            mVld = 0;
        end
        @(posedge clk);
        #1;
        if (autoDrop && a0) req0_vld = 1'b0;
        if (autoDrop && a1) req1_vld = 1'b0;
    endtask

    // Random traffic: a requester keeps its request up until it is accepted
    task automatic applyStimulus();
        if (!req0_vld && $urandom_range(0, 9) < 6) begin
            req0_vld = 1'b1;
            req0_a   = randOperand();
            req0_b   = randOperand();
            req0_op  = 1'($urandom);
        end
        if (!req1_vld && $urandom_range(0, 9) < 6) begin
            req1_vld = 1'b1;
            req1_a   = randOperand();
            req1_b   = randOperand();
            req1_op  = 1'($urandom);
        end
        rsp_rdy = ($urandom_range(0, 9) < 7);
    endtask

    logic [15:0] savedRes;

    initial begin
        rst_n = 1'b0;
        req0_vld = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_vld = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp_rdy = 0;
        mVld = 0; mLast = 1; mId = 0; mRes = 0; mOv = 0; mZ = 0; mS = 0;
        wait0 = 0; wait1 = 0; nAccepted = 0; nConsumed = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_vld", rsp_vld, 0);
        checkOutput("reset_id", rsp_id, 0);
        checkOutput("reset_result", rsp_result, 0);
        checkOutput("reset_ovfl", rsp_ovfl, 0);
        checkOutput("reset_zero", rsp_zero, 0);
        checkOutput("reset_sign", rsp_sign, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // req0: 0x7FFF - (-1) overflows positive
        req0_vld = 1; req0_a = 16'h7FFF; req0_b = 16'hFFFF; req0_op = 1;
        tick(0);
        req0_vld = 0;
        checkOutput("t1_vld", rsp_vld, 1);
        checkOutput("t1_id", rsp_id, 0);
        checkOutput("t1_ovfl", rsp_ovfl, 1);
        checkOutput("t1_zero", rsp_zero, 0);
`ifdef ALU_ARB_SAT_EN
        checkOutput("t1_result", rsp_result, 16'h7FFF);
        checkOutput("t1_sign", rsp_sign, 0);
`else
        checkOutput("t1_result", rsp_result, 16'h8000);
        checkOutput("t1_sign", rsp_sign, 1);
`endif

        // req1: 0x8000 - 1 overflows negative, back-to-back with draining
        rsp_rdy = 1;
        req1_vld = 1; req1_a = 16'h8000; req1_b = 16'h0001; req1_op = 1;
        tick(0);
        req1_vld = 0;
        checkOutput("t2_id", rsp_id, 1);
        checkOutput("t2_ovfl", rsp_ovfl, 1);
`ifdef ALU_ARB_SAT_EN
        checkOutput("t2_result", rsp_result, 16'h8000);
        checkOutput("t2_sign", rsp_sign, 1);
`else
        checkOutput("t2_result", rsp_result, 16'h7FFF);
        checkOutput("t2_sign", rsp_sign, 0);
`endif
        req1_vld = 1; req1_a = 16'd5; req1_b = 16'hFFFB; req1_op = 0;
        tick(0);
        req1_vld = 0;
        checkOutput("t2b_result", rsp_result, 0);
        checkOutput("t2b_zero", rsp_zero, 1);
        checkOutput("t2b_ovfl", rsp_ovfl, 0);
        checkOutput("t2b_id", rsp_id, 1);

        // Continuous contention: ids must alternate starting with req0
        req0_vld = 1; req1_vld = 1; rsp_rdy = 1;
        for (int i = 0; i < 6; i++) begin
            req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = 1'($urandom);
            req1_a = 16'($urandom); req1_b = 16'($urandom); req1_op = 1'($urandom);
            tick(0);
            checkOutput("rr_vld", rsp_vld, 1);
            checkOutput("rr_id", rsp_id, i % 2);
        end

        // Backpressure: buffer full, consumer stalled for 3 cycles
        rsp_rdy = 0;
        savedRes = rsp_result;
        for (int i = 0; i < 3; i++) begin
            tick(0);
            checkOutput("bp_result", rsp_result, savedRes);
            checkOutput("bp_id", rsp_id, 1);
            checkOutput("bp_r0", req0_rdy, 0);
            checkOutput("bp_r1", req1_rdy, 0);
        end
        rsp_rdy = 1;
        #1;
        checkOutput("release_r0", req0_rdy, 1);
        checkOutput("release_r1", req1_rdy, 0);
        tick(0);
        checkOutput("release_id", rsp_id, 0);

        // Asynchronous reset while full with req0 pending
        req1_vld = 0; rsp_rdy = 0; req0_vld = 1;
        tick(0);
        checkOutput("prerst_vld", rsp_vld, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_vld", rsp_vld, 0);
        checkOutput("rst_result", rsp_result, 0);
        mVld = 0; mLast = 1; wait0 = 0; wait1 = 0;
        @(posedge clk);
        #1;
        checkOutput("rst_hold_vld", rsp_vld, 0);
        req0_vld = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req0_vld = 1; req1_vld = 1; rsp_rdy = 1;
        #1;
        checkOutput("postrst_r0", req0_rdy, 1);
        checkOutput("postrst_r1", req1_rdy, 0);
        tick(0);
        checkOutput("postrst_id", rsp_id, 0);

        // Drain, then randomized traffic with loss/duplication accounting
        req0_vld = 0; req1_vld = 0; rsp_rdy = 1;
        tick(0);
        nAccepted = 0; nConsumed = 0;
        for (int i = 0; i < 10000; i++) begin
            applyStimulus();
            tick(1);
        end
        checkOutput("conserve", nAccepted, nConsumed + int'(rsp_vld));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
